// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types and constants for the data-memory access unit
package mem_access_pkg;

  typedef enum logic [1:0] {
    OP_LWP = 2'b00,
    OP_SWP = 2'b01,
    OP_LBP = 2'b10,
    OP_SBP = 2'b11
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    SPLIT,
    RESP
  } mau_state_t;

  localparam int WORD_BYTES = 4;

  // op[1] selects byte width, op[0] selects store
  function automatic logic op_is_byte(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_store(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// rtl/byte_lane_merge.sv - replaces byte lane 'lane' of a word with byte_in
module byte_lane_merge
  import mem_access_pkg::*;
(
  input  logic [WORD_BYTES*8-1:0] word,
  input  logic [7:0]              byte_in,
  input  logic [1:0]              lane,
  output logic [WORD_BYTES*8-1:0] merged
);

  always_comb begin
    merged = word;
    merged[8*lane +: 8] = byte_in;
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - core-side data-memory initiator with unaligned word splitting
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_LIMIT     = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  output logic                     mem_we,
  output logic                     mem_be,
  input  logic [DATA_WIDTH-1:0]    mem_read_data
);

  localparam logic [ADDRESS_WIDTH:0] LIMIT     = (ADDRESS_WIDTH+1)'(MEM_LIMIT);
  localparam logic [ADDRESS_WIDTH:0] WORD_TAIL = (ADDRESS_WIDTH+1)'(WORD_BYTES - 1);
  localparam logic [DATA_WIDTH-9:0]  PAD       = '0;

  mau_state_t               state;
  mem_op_t                  op_q;
  mem_op_t                  req_op_e;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [1:0]               k_q;
  logic [1:0]               k_next;
  logic [ADDRESS_WIDTH:0]   last_byte;
  logic                     req_oob;
  logic                     req_direct;
  logic [DATA_WIDTH-1:0]    merged;

  // One extra address bit keeps addr+3 from wrapping back into range
  always_comb begin
    req_op_e   = mem_op_t'(req_op);
    last_byte  = {1'b0, req_addr} + (op_is_byte(req_op) ? {(ADDRESS_WIDTH+1){1'b0}} : WORD_TAIL);
    req_oob    = (last_byte >= LIMIT);
    req_direct = op_is_byte(req_op) || (req_addr[1:0] == 2'b00);
    k_next     = k_q + 2'd1;
  end

  byte_lane_merge u_merge (
    .word    (resp_rdata),
    .byte_in (mem_read_data[7:0]),
    .lane    (k_q),
    .merged  (merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      op_q           <= OP_LWP;
      addr_q         <= '0;
      wdata_q        <= '0;
      k_q            <= 2'd0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_we         <= 1'b0;
      mem_be         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q       <= req_op_e;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            k_q        <= 2'd0;
            req_ready  <= 1'b0;
            resp_rdata <= '0;
            if (req_oob) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_direct) begin
              state       <= ACCESS;
              mem_address <= req_addr;
              mem_be      <= op_is_byte(req_op);
              mem_we      <= op_is_store(req_op);
              case (req_op_e)
                OP_SWP:  mem_write_data <= req_wdata;
                OP_SBP:  mem_write_data <= {PAD, req_wdata[7:0]};
                default: mem_write_data <= '0;
              endcase
            end else begin
              state          <= SPLIT;
              mem_address    <= req_addr;
              mem_be         <= 1'b1;
              mem_we         <= (req_op_e == OP_SWP);
              mem_write_data <= {PAD, req_wdata[7:0]};
            end
          end
        end
        ACCESS: begin
          if (!op_is_store(op_q)) resp_rdata <= mem_read_data;
          state          <= RESP;
          resp_valid     <= 1'b1;
          mem_address    <= '0;
          mem_write_data <= '0;
          mem_we         <= 1'b0;
          mem_be         <= 1'b0;
        end
        SPLIT: begin
          if (op_q == OP_LWP) resp_rdata <= merged;
          if (k_q == 2'd3) begin
            state          <= RESP;
            resp_valid     <= 1'b1;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_we         <= 1'b0;
            mem_be         <= 1'b0;
          end else begin
            k_q            <= k_next;
            mem_address    <= addr_q + ADDRESS_WIDTH'(k_next);
            mem_write_data <= {PAD, wdata_q[8*k_next +: 8]};
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_we;
  logic        mem_be;
  logic [31:0] mem_read_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem     [0:1023];
  logic [7:0]  ref_mem [0:1023];
  int          be_cnt;
  int          act_cnt;
  logic [31:0] be_addr[$];

  mem_access_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .MEM_LIMIT(1024)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_we         (mem_we),
    .mem_be         (mem_be),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  // Data memory: synchronous writes, combinational little-endian reads
  wire [9:0] ma = mem_address[9:0];
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_be) mem[ma] <= mem_write_data[7:0];
      else for (int i = 0; i < 4; i++) mem[ma + 10'(i)] <= mem_write_data[8*i +: 8];
    end
  end

  always_comb begin
    if (mem_be) mem_read_data = {24'b0, mem[ma]};
    else        mem_read_data = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};
  end

  always @(negedge clk) begin
    if (mem_be) begin
      be_cnt++;
      be_addr.push_back(mem_address);
    end
    if (mem_we || mem_be) act_cnt++;
  end

  // Reference: architectural effect of one request on a flat byte memory
  task automatic ref_apply(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output int lat);
    longint last;
    int     a;
    last = longint'(addr) + (op[1] ? 0 : 3);
    rd   = 32'h0;
    er   = (last >= 1024);
    lat  = 1;
    if (er) return;
    a   = int'(addr);
    lat = (op[1] || (a % 4 == 0)) ? 2 : 5;
    case (op)
      2'b00: for (int i = 0; i < 4; i++) rd[8*i +: 8] = ref_mem[a + i];
      2'b01: for (int i = 0; i < 4; i++) ref_mem[a + i] = wd[8*i +: 8];
      2'b10: rd = {24'b0, ref_mem[a]};
      default: ref_mem[a] = wd[7:0];
    endcase
  endtask

  task automatic send_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          output int lat);
    int n;
    be_cnt = 0;
    act_cnt = 0;
    be_addr.delete();
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!resp_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL resp_timeout: resp_valid=%0b required 1 within 50 cycles", resp_valid);
    end
  endtask

  task automatic ack_resp();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({req_ready, resp_valid, resp_err, mem_we, mem_be} !== 5'b10000 ||
        resp_rdata !== 32'h0 || mem_address !== 32'h0 || mem_write_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%0b vld=%0b err=%0b we=%0b be=%0b rd=%h a=%h wd=%h required rdy=1 rest 0",
               req_ready, resp_valid, resp_err, mem_we, mem_be, resp_rdata, mem_address, mem_write_data);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_aligned();
    logic [31:0] erd; logic eer; int elat; int lat;
    ref_apply(2'b01, 32'h10, 32'hDEADBEEF, erd, eer, elat);
    send_req(2'b01, 32'h10, 32'hDEADBEEF, lat);
    n_checks++;
    if (lat !== 2 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL aligned_store: lat=%0d err=%0b rd=%h required lat=2 err=0 rd=0", lat, resp_err, resp_rdata);
    end
    ack_resp();
    ref_apply(2'b00, 32'h10, 32'h0, erd, eer, elat);
    send_req(2'b00, 32'h10, 32'h0, lat);
    n_checks++;
    if (lat !== 2 || resp_err !== 1'b0 || resp_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL aligned_load: lat=%0d err=%0b rd=%h required lat=2 err=0 rd=deadbeef", lat, resp_err, resp_rdata);
    end
    ack_resp();
  endtask

  task automatic test_byte();
    logic [31:0] erd; logic eer; int elat; int lat;
    ref_apply(2'b11, 32'h05, 32'h000000AB, erd, eer, elat);
    send_req(2'b11, 32'h05, 32'h000000AB, lat);
    n_checks++;
    if (lat !== 2 || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL byte_store: lat=%0d err=%0b required lat=2 err=0", lat, resp_err);
    end
    ack_resp();
    ref_apply(2'b00, 32'h04, 32'h0, erd, eer, elat);
    send_req(2'b00, 32'h04, 32'h0, lat);
    n_checks++;
    if (resp_rdata !== 32'h0000AB00) begin
      n_fail++;
      $display("FAIL byte_word_view: rd=%h required 0000ab00", resp_rdata);
    end
    ack_resp();
    ref_apply(2'b10, 32'h05, 32'h0, erd, eer, elat);
    send_req(2'b10, 32'h05, 32'h0, lat);
    n_checks++;
    if (resp_rdata !== 32'h000000AB || lat !== 2) begin
      n_fail++;
      $display("FAIL byte_load: rd=%h lat=%0d required 000000ab lat=2", resp_rdata, lat);
    end
    ack_resp();
  endtask

  task automatic test_split_load();
    logic [31:0] erd; logic eer; int elat; int lat;
    ref_apply(2'b01, 32'h20, 32'h44332211, erd, eer, elat);
    send_req(2'b01, 32'h20, 32'h44332211, lat);
    ack_resp();
    ref_apply(2'b01, 32'h24, 32'h88776655, erd, eer, elat);
    send_req(2'b01, 32'h24, 32'h88776655, lat);
    ack_resp();
    ref_apply(2'b00, 32'h22, 32'h0, erd, eer, elat);
    send_req(2'b00, 32'h22, 32'h0, lat);
    n_checks++;
    if (resp_rdata !== 32'h66554433 || lat !== 5 || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL split_load: rd=%h lat=%0d err=%0b required 66554433 lat=5 err=0", resp_rdata, lat, resp_err);
    end
    n_checks++;
    if (be_cnt !== 4) begin
      n_fail++;
      $display("FAIL split_load_count: byte accesses=%0d required 4", be_cnt);
    end
    for (int i = 0; i < 4 && i < be_addr.size(); i++) begin
      n_checks++;
      if (be_addr[i] !== 32'h22 + 32'(i)) begin
        n_fail++;
        $display("FAIL split_load_addr%0d: addr=%h required %h", i, be_addr[i], 32'h22 + 32'(i));
      end
    end
    ack_resp();
  endtask

  task automatic test_split_store();
    logic [31:0] erd; logic eer; int elat; int lat;
    logic [7:0] exp_b [4];
    exp_b = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
    ref_apply(2'b01, 32'h31, 32'hCAFEF00D, erd, eer, elat);
    send_req(2'b01, 32'h31, 32'hCAFEF00D, lat);
    n_checks++;
    if (lat !== 5 || be_cnt !== 4) begin
      n_fail++;
      $display("FAIL split_store: lat=%0d byte accesses=%0d required lat=5 accesses=4", lat, be_cnt);
    end
    ack_resp();
    for (int i = 0; i < 4; i++) begin
      ref_apply(2'b10, 32'h31 + 32'(i), 32'h0, erd, eer, elat);
      send_req(2'b10, 32'h31 + 32'(i), 32'h0, lat);
      n_checks++;
      if (resp_rdata !== {24'b0, exp_b[i]}) begin
        n_fail++;
        $display("FAIL split_store_byte%0d: rd=%h required %h", i, resp_rdata, {24'b0, exp_b[i]});
      end
      ack_resp();
    end
    send_req(2'b10, 32'h30, 32'h0, lat);
    n_checks++;
    if (resp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL split_store_neighbour: rd=%h required 0", resp_rdata);
    end
    ack_resp();
  endtask

  task automatic test_error();
    logic [31:0] erd; logic eer; int elat; int lat;
    logic [1:0]  ops   [6];
    logic [31:0] addrs [6];
    ops   = '{2'b00, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    addrs = '{32'd1022, 32'd1020, 32'd1023, 32'd1024, 32'd1021, 32'hFFFFFFFE};
    for (int i = 0; i < 6; i++) begin
      ref_apply(ops[i], addrs[i], 32'h5A5A5A5A, erd, eer, elat);
      send_req(ops[i], addrs[i], 32'h5A5A5A5A, lat);
      n_checks++;
      if (resp_err !== eer || resp_rdata !== erd || lat !== elat) begin
        n_fail++;
        $display("FAIL range_%0d: err=%0b rd=%h lat=%0d required err=%0b rd=%h lat=%0d",
                 i, resp_err, resp_rdata, lat, eer, erd, elat);
      end
      if (eer) begin
        n_checks++;
        if (act_cnt !== 0) begin
          n_fail++;
          $display("FAIL range_%0d_no_mem: mem cycles=%0d required 0", i, act_cnt);
        end
      end
      ack_resp();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] erd; logic eer; int elat; int lat;
    ref_apply(2'b00, 32'h10, 32'h0, erd, eer, elat);
    send_req(2'b00, 32'h10, 32'h0, lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_addr  = 32'h100;
    req_wdata = 32'h12345678;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== erd || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_c%0d: vld=%0b rd=%h rdy=%0b required vld=1 rd=%h rdy=0",
                 c, resp_valid, resp_rdata, req_ready, erd);
      end
    end
    req_valid = 1'b0;
    n_checks++;
    if (act_cnt !== 0) begin
      n_fail++;
      $display("FAIL backpressure_ignored: mem cycles=%0d required 0", act_cnt);
    end
    ack_resp();
    n_checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL resp_clear: vld=%0b rd=%h err=%0b rdy=%0b required 0 0 0 1",
               resp_valid, resp_rdata, resp_err, req_ready);
    end
  endtask

  task automatic test_reset_mid_split();
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_addr  = 32'h41;
    req_wdata = 32'h11223344;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (mem_address !== 32'h43 || mem_write_data !== 32'h22 || mem_we !== 1'b1 || mem_be !== 1'b1) begin
      n_fail++;
      $display("FAIL split_k2: a=%h wd=%h we=%0b be=%0b required a=43 wd=22 we=1 be=1",
               mem_address, mem_write_data, mem_we, mem_be);
    end
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, resp_valid, resp_err, mem_we, mem_be} !== 5'b10000 ||
        resp_rdata !== 32'h0 || mem_address !== 32'h0 || mem_write_data !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: rdy=%0b vld=%0b err=%0b we=%0b be=%0b a=%h wd=%h required rdy=1 rest 0",
               req_ready, resp_valid, resp_err, mem_we, mem_be, mem_address, mem_write_data);
    end
    ref_mem[32'h41] = 8'h44;
    ref_mem[32'h42] = 8'h33;
    n_checks++;
    if (mem[32'h41] !== 8'h44 || mem[32'h42] !== 8'h33 || mem[32'h43] !== ref_mem[32'h43]) begin
      n_fail++;
      $display("FAIL partial_commit: m41=%h m42=%h m43=%h required 44 33 %h",
               mem[32'h41], mem[32'h42], mem[32'h43], ref_mem[32'h43]);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: rdy=%0b vld=%0b required rdy=1 vld=0", req_ready, resp_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] erd; logic eer; int elat; int lat;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    for (int i = 0; i < 60; i++) begin
      op   = 2'($urandom_range(0, 3));
      addr = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1016, 1030)) : 32'($urandom_range(0, 1023));
      wd   = $urandom;
      ref_apply(op, addr, wd, erd, eer, elat);
      send_req(op, addr, wd, lat);
      n_checks++;
      if (resp_rdata !== erd || resp_err !== eer || lat !== elat) begin
        n_fail++;
        $display("FAIL random_%0d op=%0d addr=%h: rd=%h err=%0b lat=%0d required rd=%h err=%0b lat=%0d",
                 i, op, addr, resp_rdata, resp_err, lat, erd, eer, elat);
      end
      ack_resp();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    test_reset();
    test_aligned();
    test_byte();
    test_split_load();
    test_split_store();
    test_error();
    test_backpressure();
    test_reset_mid_split();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
